wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline write-back path and a multi-cycle long-latency unit (MUL/DIV).
- Buffers long-latency results in a small FIFO and gives the pipeline priority, with a starvation guard.
- Keeps a 32-bit scoreboard of registers pending long-latency write-back, read by the hazard unit.
- Sits between the WB-stage outputs / long-latency unit result port and the register file write port.

Parameters:
DEPTH, 2, long-latency result FIFO entries (power of 2, >=2)
STARVE_MAX, 4, consecutive cycles a non-empty FIFO may be bypassed before a forced grant

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-low
p_regwrite  input  1  pipeline write-back request
p_rd_addr  input  5  pipeline destination register
p_rd_data  input  32  pipeline write data
iss_valid  input  1  long-latency op issued this cycle
iss_rd  input  5  destination of issued long-latency op
l_valid  input  1  long-latency result valid
l_ready  output  1  FIFO can accept a result (= !full)
l_rd_addr  input  5  long-latency destination register
l_rd_data  input  32  long-latency result
pipe_stall  output  1  pipeline must hold WB (and upstream) this cycle
rf_we  output  1  register file write enable (registered)
rf_waddr  output  5  register file write address (registered)
rf_wdata  output  32  register file write data (registered)
rd_busy  output  32  scoreboard, bit i = xi has pending long-latency write

Behaviour:
- Reset (rst==0 at clk edge): FIFO empty, stv_cnt=0, FSM=NORMAL, rd_busy=0, rf_we=0, rf_waddr=0, rf_wdata=0. Reset mid-operation discards all buffered results and pending scoreboard bits.
- Requests to x0: a pipeline write with p_rd_addr==0 is not a request. A long-latency result with rd 0 is accepted into the FIFO and popped normally, but rf_we stays 0 for it. iss_rd==0 never sets a busy bit.
- FIFO push: l_valid && l_ready. l_ready=0 when full; no same-cycle push-through when full.
- Pipeline latency: p request at cycle t -> rf_we/rf_waddr/rf_wdata at t+1.
- Long-latency latency: result accepted at t -> entry visible at t+1 -> earliest rf_we at t+2.
- FSM NORMAL:
  - Pipeline request present (p_regwrite, rd!=0): grant pipeline, pipe_stall=0. If the FIFO is non-empty, stv_cnt++.
  - Otherwise, FIFO non-empty: pop head, grant it, stv_cnt=0.
  - When stv_cnt reaches STARVE_MAX: next cycle FSM=FORCE.
- FSM FORCE (exactly one cycle):
  - pipe_stall=1 (combinational) and FIFO head granted, regardless of p_regwrite.
  - Pipeline holds its inputs; the held request is granted next cycle.
  - stv_cnt=0, return to NORMAL.
- If the FIFO empties while stv_cnt>0, stv_cnt=0.
- pipe_stall is 0 in NORMAL. The pipeline write is never dropped.
- Scoreboard:
  - iss_valid sets rd_busy[iss_rd].
  - A committed long-latency write (pop granted) clears rd_busy[rf_waddr] in the same edge that registers rf_we.
  - Same-cycle set and clear of the same register: set wins (new issue).
  - A pipeline write to a busy register does not clear the bit.
- No grant -> rf_we=0. rf_waddr/rf_wdata hold their previous values.

Test Plan:
- Reset: drive rst=0 for 2 cycles with l_valid=1, p_regwrite=1 -> rf_we=0, rd_busy=0, l_ready=1 after reset.
- Pipeline only: p_regwrite=1, rd=5, data=0xDEADBEEF at t -> rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF at t+1; rd=0 -> rf_we=0.
- Long-latency only: iss_valid rd=7 -> rd_busy[7]=1; later l_valid rd=7 data=0x12 at t -> rf_we at t+2 with 0x12, rd_busy[7]=0 after that edge.
- Full FIFO: 3 back-to-back l_valid while pipeline writes every cycle -> l_ready=0 after 2 pushes (DEPTH=2), third held until a pop.
- Starvation: FIFO holds 1 entry, p_regwrite=1 continuously -> after 4 pipeline grants, pipe_stall=1 for one cycle and the FIFO entry is written. The pipeline request is written the following cycle.
- Collision: iss_valid rd=9 in the same cycle a rd=9 result commits -> rd_busy[9] remains 1.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: shares the single write port between the
// in-order pipeline write-back path and a long-latency unit (MUL/DIV). Results
// from the long-latency unit queue in a small FIFO. The pipeline normally wins,
// but a starvation counter forces one FIFO drain cycle after STARVE_MAX bypasses.
// A 32-bit scoreboard tracks registers still awaiting a long-latency write.
module wb_port_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p_regwrite,
    input  logic [4:0]  p_rd_addr,
    input  logic [31:0] p_rd_data,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    input  logic        l_valid,
    output logic        l_ready,
    input  logic [4:0]  l_rd_addr,
    input  logic [31:0] l_rd_data,
    output logic        pipe_stall,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] rd_busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [SW-1:0]  stv_cnt;
    logic [SW-1:0]  stv_next;

    logic [4:0]     fifo_addr [DEPTH];
    logic [31:0]    fifo_data [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_next;

    logic           empty;
    logic           full;
    logic           push;
    logic           pop;
    logic           p_req;
    logic           grant_pipe;
    logic           commit;
    logic [4:0]     head_addr;
    logic [31:0]    head_data;
    logic [31:0]    busy_next;

    // Request decode: x0 is never a real pipeline write, and a full FIFO
    // refuses new results outright (no push-through while full).
    always_comb begin
        empty     = (count == '0);
        full      = (count == CW'(DEPTH));
        l_ready   = !full;
        push      = l_valid && !full;
        p_req     = p_regwrite && (p_rd_addr != 5'd0);
        head_addr = fifo_addr[rd_ptr];
        head_data = fifo_data[rd_ptr];
    end

    // Arbitration: pipeline first, FIFO when the pipeline is idle, and one
    // forced FIFO grant with the pipeline stalled once it has been starved.
    always_comb begin
        state_next = state;
        stv_next   = stv_cnt;
        grant_pipe = 1'b0;
        pop        = 1'b0;
        pipe_stall = 1'b0;
        case (state)
            ST_NORMAL: begin
                if (p_req) begin
                    grant_pipe = 1'b1;
                    if (!empty) begin
                        stv_next = stv_cnt + SW'(1);
                        if (stv_cnt == SW'(STARVE_MAX - 1)) begin
                            state_next = ST_FORCE;
                        end
                    end else begin
                        stv_next = '0;
                    end
                end else if (!empty) begin
                    pop      = 1'b1;
                    stv_next = '0;
                end else begin
                    stv_next = '0;
                end
            end
            ST_FORCE: begin
                pipe_stall = 1'b1;
                pop        = !empty;
                stv_next   = '0;
                state_next = ST_NORMAL;
            end
            default: begin
                state_next = ST_NORMAL;
                stv_next   = '0;
            end
        endcase
    end

    // A popped result aimed at x0 is drained but never written.
    always_comb begin
        commit = pop && (head_addr != 5'd0);
    end

    // FIFO occupancy follows push/pop; simultaneous push and pop cancel out.
    always_comb begin
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Scoreboard update: a commit clears its register, a new issue sets its
    // register afterwards so that an issue colliding with a commit stays busy.
    always_comb begin
        busy_next = rd_busy;
        if (commit) begin
            busy_next[head_addr] = 1'b0;
        end
        if (iss_valid && (iss_rd != 5'd0)) begin
            busy_next[iss_rd] = 1'b1;
        end
    end

    // Arbiter state register and starvation counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_NORMAL;
            stv_cnt <= '0;
        end else begin
            state   <= state_next;
            stv_cnt <= stv_next;
        end
    end

    // FIFO pointers and occupancy; reset throws away any buffered results.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
        end
    end

    // FIFO storage; contents are only meaningful behind the occupancy count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= l_rd_addr;
            fifo_data[wr_ptr] <= l_rd_data;
        end
    end

    // Registered write port; address and data hold when nothing is written.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= 32'd0;
        end else if (grant_pipe) begin
            rf_we    <= 1'b1;
            rf_waddr <= p_rd_addr;
            rf_wdata <= p_rd_data;
        end else if (commit) begin
            rf_we    <= 1'b1;
            rf_waddr <= head_addr;
            rf_wdata <= head_data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    // Pending long-latency write scoreboard.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_busy <= 32'd0;
        end else begin
            rd_busy <= busy_next;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a queue-based model.
module tb_wb_port_arbiter;

    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        p_regwrite;
    logic [4:0]  p_rd_addr;
    logic [31:0] p_rd_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        l_valid;
    logic        l_ready;
    logic [4:0]  l_rd_addr;
    logic [31:0] l_rd_data;
    logic        pipe_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] rd_busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst;
        logic        pw;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        iv;
        logic [4:0]  ir;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic        chk_pre;
        logic        e_stall;
        logic        e_ready;
        logic        e_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic [31:0] e_busy;
    } vec_t;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    // Reference model state: result queue, bypass count, forced-drain flag.
    ent_t        m_q[$];
    int          m_bypass;
    bit          m_forcing;
    logic [31:0] m_busy;
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    vec_t tbl[14];

    wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .p_regwrite (p_regwrite),
        .p_rd_addr  (p_rd_addr),
        .p_rd_data  (p_rd_data),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .l_valid    (l_valid),
        .l_ready    (l_ready),
        .l_rd_addr  (l_rd_addr),
        .l_rd_data  (l_rd_data),
        .pipe_stall (pipe_stall),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .rd_busy    (rd_busy)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst        = v.rst;
        p_regwrite = v.pw;
        p_rd_addr  = v.pa;
        p_rd_data  = v.pd;
        iss_valid  = v.iv;
        iss_rd     = v.ir;
        l_valid    = v.lv;
        l_rd_addr  = v.la;
        l_rd_data  = v.ld;
    endtask

    // One clock of a directed vector: combinational checks before the edge,
    // registered checks just after it.
    task automatic runVec(input vec_t v, input string tag);
        applyStimulus(v);
        #1;
        if (v.chk_pre) begin
            checkOutput({tag, ".pipe_stall"}, 32'(pipe_stall), 32'(v.e_stall));
            checkOutput({tag, ".l_ready"}, 32'(l_ready), 32'(v.e_ready));
        end
        @(posedge clk);
        #1;
        checkOutput({tag, ".rf_we"}, 32'(rf_we), 32'(v.e_we));
        checkOutput({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(v.e_waddr));
        checkOutput({tag, ".rf_wdata"}, rf_wdata, v.e_wdata);
        checkOutput({tag, ".rd_busy"}, rd_busy, v.e_busy);
    endtask

    task automatic doReset(input string tag);
        runVec('{1'b0, 1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 1'b1, 5'd5, 32'h2,
                 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0}, {tag, ".rst0"});
        runVec('{1'b0, 1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 1'b1, 5'd5, 32'h2,
                 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0}, {tag, ".rst1"});
    endtask

    // Behavioural reference: advances one clock using the current inputs.
    task automatic modelStep();
        bit   do_pop;
        bit   can_push;
        ent_t e;
        if (!rst) begin
            m_q.delete();
            m_bypass  = 0;
            m_forcing = 0;
            m_busy    = 32'd0;
            m_we      = 1'b0;
            m_waddr   = 5'd0;
            m_wdata   = 32'd0;
        end else begin
            do_pop   = 0;
            can_push = (m_q.size() < DEPTH);
            m_we     = 1'b0;
            if (m_forcing) begin
                do_pop    = (m_q.size() > 0);
                m_forcing = 0;
                m_bypass  = 0;
            end else if (p_regwrite && p_rd_addr != 5'd0) begin
                m_we    = 1'b1;
                m_waddr = p_rd_addr;
                m_wdata = p_rd_data;
                if (m_q.size() > 0) begin
                    m_bypass++;
                    if (m_bypass >= STARVE_MAX) m_forcing = 1;
                end
            end else if (m_q.size() > 0) begin
                do_pop   = 1;
                m_bypass = 0;
            end
            if (do_pop) begin
                e = m_q.pop_front();
                if (e.a != 5'd0) begin
                    m_we        = 1'b1;
                    m_waddr     = e.a;
                    m_wdata     = e.d;
                    m_busy[e.a] = 1'b0;
                end
            end
            if (l_valid && can_push) begin
                e.a = l_rd_addr;
                e.d = l_rd_data;
                m_q.push_back(e);
            end
            if (m_q.size() == 0) m_bypass = 0;
            if (iss_valid && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
        end
    endtask

    initial begin
        // Reset, pipeline-only, long-latency-only and x0 cases.
        tbl[0]  = '{1'b0, 1'b1, 5'd5, 32'h1, 1'b1, 5'd3, 1'b1, 5'd3, 32'h1,
                    1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0};
        tbl[1]  = '{1'b0, 1'b1, 5'd5, 32'h1, 1'b1, 5'd3, 1'b1, 5'd3, 32'h1,
                    1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0};
        tbl[2]  = '{1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,
                    1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 32'h0};
        tbl[3]  = '{1'b1, 1'b1, 5'd0, 32'h1111, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,
                    1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0};
        tbl[4]  = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0,
                    1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 32'h80};
        tbl[5]  = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0, 32'h0,
                    1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 32'h80};
        tbl[6]  = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd7, 32'h12,
                    1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 32'h80};
        tbl[7]  = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,
                    1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h12, 32'h0};
        tbl[8]  = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,
                    1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 32'h12, 32'h0};
        tbl[9]  = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd0, 32'h55,
                    1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 32'h12, 32'h0};
        tbl[10] = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,
                    1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 32'h12, 32'h0};
        tbl[11] = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,
                    1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 32'h12, 32'h0};
        tbl[12] = '{1'b1, 1'b1, 5'd9, 32'hAB, 1'b1, 5'd12, 1'b0, 5'd0, 32'h0,
                    1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'hAB, 32'h1000};
        tbl[13] = '{1'b1, 1'b1, 5'd12, 32'hCD, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,
                    1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 32'hCD, 32'h1000};

        for (int i = 0; i < 14; i++) begin
            runVec(tbl[i], $sformatf("tbl%0d", i));
        end

        // Full FIFO: third result is refused until a pop frees a slot.
        doReset("full");
        runVec('{1'b1, 1'b1, 5'd1, 32'hA0, 1'b0, 5'd0, 1'b1, 5'd10, 32'd100,
                 1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 32'hA0, 32'h0}, "full.a");
        runVec('{1'b1, 1'b1, 5'd2, 32'hA1, 1'b0, 5'd0, 1'b1, 5'd11, 32'd101,
                 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 32'hA1, 32'h0}, "full.b");
        runVec('{1'b1, 1'b1, 5'd3, 32'hA2, 1'b0, 5'd0, 1'b1, 5'd12, 32'd102,
                 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'hA2, 32'h0}, "full.c");
        runVec('{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd12, 32'd102,
                 1'b1, 1'b0, 1'b0, 1'b1, 5'd10, 32'd100, 32'h0}, "full.d");
        runVec('{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd12, 32'd102,
                 1'b1, 1'b0, 1'b1, 1'b1, 5'd11, 32'd101, 32'h0}, "full.e");
        runVec('{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 32'd102, 32'h0}, "full.f");
        runVec('{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b0, 1'b1, 1'b0, 5'd12, 32'd102, 32'h0}, "full.g");

        // Starvation: four bypasses, one forced drain, then the held request.
        doReset("starve");
        runVec('{1'b1, 1'b1, 5'd1, 32'h11, 1'b1, 5'd20, 1'b1, 5'd20, 32'h200,
                 1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 32'h11, 32'h100000}, "starve.0");
        for (int k = 1; k <= 4; k++) begin
            runVec('{1'b1, 1'b1, 5'(k + 1), 32'(16 + k), 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,
                     1'b1, 1'b0, 1'b1, 1'b1, 5'(k + 1), 32'(16 + k), 32'h100000},
                   $sformatf("starve.%0d", k));
        end
        runVec('{1'b1, 1'b1, 5'd6, 32'h16, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b1, 1'b1, 1'b1, 5'd20, 32'h200, 32'h0}, "starve.force");
        runVec('{1'b1, 1'b1, 5'd6, 32'h16, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 32'h16, 32'h0}, "starve.held");
        runVec('{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b0, 1'b1, 1'b0, 5'd6, 32'h16, 32'h0}, "starve.idle");

        // Collision: re-issue to x9 while its previous result commits.
        doReset("coll");
        runVec('{1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h200}, "coll.iss");
        runVec('{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd9, 32'h99,
                 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h200}, "coll.push");
        runVec('{1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h99, 32'h200}, "coll.commit");
        runVec('{1'b1, 1'b1, 5'd9, 32'h77, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h77, 32'h200}, "coll.pwrite");
        runVec('{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd9, 32'h98,
                 1'b1, 1'b0, 1'b1, 1'b0, 5'd9, 32'h77, 32'h200}, "coll.push2");
        runVec('{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h98, 32'h0}, "coll.clear");

        // Randomized traffic against the reference model.
        doReset("rand");
        m_q.delete();
        m_bypass  = 0;
        m_forcing = 0;
        m_busy    = 32'd0;
        m_we      = 1'b0;
        m_waddr   = 5'd0;
        m_wdata   = 32'd0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) != 0);
            if (!m_forcing) begin
                p_regwrite = ($urandom_range(0, 9) < 7);
                p_rd_addr  = 5'($urandom_range(0, 15));
                p_rd_data  = $urandom;
            end
            iss_valid = ($urandom_range(0, 3) == 0);
            iss_rd    = 5'($urandom_range(0, 15));
            l_valid   = ($urandom_range(0, 9) < 4);
            l_rd_addr = 5'($urandom_range(0, 15));
            l_rd_data = $urandom;
            #1;
            checkOutput("rand.pipe_stall", 32'(pipe_stall), 32'(m_forcing));
            checkOutput("rand.l_ready", 32'(l_ready), 32'(m_q.size() < DEPTH));
            modelStep();
            @(posedge clk);
            #1;
            checkOutput("rand.rf_we", 32'(rf_we), 32'(m_we));
            checkOutput("rand.rf_waddr", 32'(rf_waddr), 32'(m_waddr));
            checkOutput("rand.rf_wdata", rf_wdata, m_wdata);
            checkOutput("rand.rd_busy", rd_busy, m_busy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
